// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tank_pkg
//  Description : Shared constants, load-FSM state type and a row popcount
//                helper for the brick map controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package tank_pkg;

    // Edge length of one map tile in pixels
    localparam int TILE_PX           = 16;
    // Default playfield size in tiles (width and height)
    localparam int MAP_TILES_DEFAULT = 26;
    // Width of a tile row/column index
    localparam int TILE_IDX_W        = 5;
    // Width of the brick counter (holds up to 26*26 = 676)
    localparam int COUNT_W           = 10;

    // Level-load sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

    // Number of set bits in a (zero-extended) map row
    function automatic logic [5:0] row_popcount(input logic [31:0] row);
        logic [5:0] n;
        n = '0;
        for (int b = 0; b < 32; b++) begin
            n = n + 6'(row[b]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/brick_hit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : brick_hit_arbiter
//  Description : Two-way round-robin arbiter for brick hit requests. Grants
//                at most one requester per cycle while enabled; priority
//                passes to the other requester after every grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module brick_hit_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_enable,
    output logic [1:0] o_grant,
    output logic       o_ptr
);

    logic       ptr_q;
    logic       ptr_d;
    logic [1:0] w_grant;

    // Grant one requester, preferring the one the pointer names
    always_comb begin
        w_grant = 2'b00;
        if (i_enable) begin
            if (ptr_q == 1'b0) begin
                if (i_req[0]) begin
                    w_grant = 2'b01;
                end else if (i_req[1]) begin
                    w_grant = 2'b10;
                end
            end else begin
                if (i_req[1]) begin
                    w_grant = 2'b10;
                end else if (i_req[0]) begin
                    w_grant = 2'b01;
                end
            end
        end
    end

    // Hand priority to the requester that was not just served
    always_comb begin
        ptr_d = ptr_q;
        if (w_grant[0]) begin
            ptr_d = 1'b1;
        end else if (w_grant[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Priority pointer register, requester 0 favoured out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_grant = w_grant;
    assign o_ptr   = ptr_q;

endmodule
`default_nettype wire

// File: rtl/brick_map_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : brick_map_ctrl
//  Description : Brick tile map for the playfield. Loads a level from a
//                row-organised ROM, renders the bricks at pixel rate with no
//                pipeline delay, and serves brick hit requests from two
//                requesters through a round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module brick_map_ctrl
    import tank_pkg::*;
#(
    parameter int ORIGIN_X  = 32,
    parameter int ORIGIN_Y  = 32,
    parameter int MAP_TILES = MAP_TILES_DEFAULT
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    output logic                 show_brick,
    input  logic                 load_start,
    input  logic [1:0]           level_sel,
    output logic [6:0]           level_addr,
    input  logic [MAP_TILES-1:0] level_data,
    output logic                 load_busy,
    output logic                 load_done,
    input  logic [1:0]           hit_req,
    input  logic [4:0]           hit_col0,
    input  logic [4:0]           hit_row0,
    input  logic [4:0]           hit_col1,
    input  logic [4:0]           hit_row1,
    output logic [1:0]           hit_ack,
    output logic [1:0]           hit_brick,
    output logic [9:0]           brick_count
);

    // Playfield extent in pixels and top bit of the tile index in a pixel offset
    localparam int c_PLAY_PX = TILE_PX * MAP_TILES;
    localparam int c_IDX_HI  = TILE_IDX_W + 3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [MAP_TILES-1:0]  map_q [MAP_TILES];
    logic [MAP_TILES-1:0]  map_d [MAP_TILES];
    load_state_e           state_q, state_d;
    logic [TILE_IDX_W-1:0] row_q, row_d;         // row currently on level_addr
    logic [TILE_IDX_W-1:0] wr_row_q, wr_row_d;   // row whose data arrives this cycle
    logic                  addr_act_q, addr_act_d;
    logic                  pend_q, pend_d;       // level_data holds a row to write
    logic [1:0]            sel_q, sel_d;
    logic [6:0]            level_addr_q, level_addr_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [1:0]            hit_ack_q, hit_ack_d;
    logic [1:0]            hit_brick_q, hit_brick_d;

    // ------------------------------------------------------------------
    // Pixel to tile decode
    // ------------------------------------------------------------------
    logic signed [10:0]    w_dx;
    logic signed [10:0]    w_dy;
    logic                  w_in_x;
    logic                  w_in_y;
    logic [TILE_IDX_W-1:0] w_px_col;
    logic [TILE_IDX_W-1:0] w_px_row;
    logic [MAP_TILES-1:0]  w_px_bits;

    // Signed offsets so pixels left of or above the origin go negative
    assign w_dx = $signed({1'b0, DrawX}) - $signed(11'(ORIGIN_X));
    assign w_dy = $signed({1'b0, DrawY}) - $signed(11'(ORIGIN_Y));

    assign w_in_x = (w_dx >= 11'sd0) && (w_dx < $signed(11'(c_PLAY_PX)));
    assign w_in_y = (w_dy >= 11'sd0) && (w_dy < $signed(11'(c_PLAY_PX)));

    // Row/column select forced to 0 off-field so the array index stays legal
    assign w_px_col  = w_in_x ? w_dx[c_IDX_HI:4] : '0;
    assign w_px_row  = w_in_y ? w_dy[c_IDX_HI:4] : '0;
    assign w_px_bits = map_q[w_px_row];

    assign show_brick = w_in_x && w_in_y && w_px_bits[w_px_col];

    // ------------------------------------------------------------------
    // Hit request decode and arbitration
    // ------------------------------------------------------------------
    logic [TILE_IDX_W-1:0] w_hit_col [2];
    logic [TILE_IDX_W-1:0] w_hit_row [2];
    logic [TILE_IDX_W-1:0] w_hit_col_idx [2];
    logic [TILE_IDX_W-1:0] w_hit_row_idx [2];
    logic [1:0]            w_hit_ok;
    logic [1:0]            w_hit_bit;
    logic [1:0]            w_req_eff;
    logic [1:0]            w_grant;
    logic                  w_arb_en;
    logic                  w_arb_ptr;

    assign w_hit_col[0] = hit_col0;
    assign w_hit_row[0] = hit_row0;
    assign w_hit_col[1] = hit_col1;
    assign w_hit_row[1] = hit_row1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_hit
        assign w_hit_ok[gi] = ({1'b0, w_hit_col[gi]} < 6'(MAP_TILES)) &&
                              ({1'b0, w_hit_row[gi]} < 6'(MAP_TILES));
        assign w_hit_col_idx[gi] = w_hit_ok[gi] ? w_hit_col[gi] : '0;
        assign w_hit_row_idx[gi] = w_hit_ok[gi] ? w_hit_row[gi] : '0;
        assign w_hit_bit[gi]     = w_hit_ok[gi] &
                                   map_q[w_hit_row_idx[gi]][w_hit_col_idx[gi]];
    end

    // A requester whose ack is showing this cycle is still holding its old
    // request; masking it keeps one ack per request
    assign w_req_eff = hit_req & ~hit_ack_q;
    assign w_arb_en  = (state_q == ST_IDLE);

    brick_hit_arbiter u_arb (
        .clk      (vga_clk),
        .rst_n    (reset_n),
        .i_req    (w_req_eff),
        .i_enable (w_arb_en),
        .o_grant  (w_grant),
        .o_ptr    (w_arb_ptr)
    );

    // ------------------------------------------------------------------
    // Next-state: load sequencer, map writes, brick counter, hit responses
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        wr_row_d     = wr_row_q;
        addr_act_d   = addr_act_q;
        pend_d       = pend_q;
        sel_d        = sel_q;
        level_addr_d = level_addr_q;
        count_d      = count_q;
        map_d        = map_q;
        hit_ack_d    = w_grant;
        hit_brick_d  = 2'b00;

        // Destroy a brick on a granted hit; at most one grant per cycle
        for (int i = 0; i < 2; i++) begin
            if (w_grant[i] && w_hit_bit[i]) begin
                hit_brick_d[i] = 1'b1;
                map_d[w_hit_row_idx[i]][w_hit_col_idx[i]] = 1'b0;
                count_d = count_q - 10'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d      = ST_LOAD;
                    sel_d        = level_sel;
                    row_d        = '0;
                    level_addr_d = {level_sel, 5'd0};
                    addr_act_d   = 1'b1;
                    pend_d       = 1'b0;
                    // The level replaces the map, so a same-cycle hit is moot
                    count_d      = '0;
                end
            end
            ST_LOAD: begin
                // ROM data lags the address by one cycle: write the previous row
                if (pend_q) begin
                    map_d[wr_row_q] = level_data;
                    count_d = count_q + 10'(row_popcount(32'(level_data)));
                end
                pend_d   = addr_act_q;
                wr_row_d = row_q;
                if (addr_act_q) begin
                    if (row_q == 5'(MAP_TILES - 1)) begin
                        addr_act_d = 1'b0;
                    end else begin
                        row_d        = row_q + 5'd1;
                        level_addr_d = {sel_q, row_q + 5'd1};
                    end
                end else if (pend_q) begin
                    // Drain cycle: last row just written
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register all state; reset clears the map and aborts any load
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < MAP_TILES; r++) begin
                map_q[r] <= '0;
            end
            state_q      <= ST_IDLE;
            row_q        <= '0;
            wr_row_q     <= '0;
            addr_act_q   <= 1'b0;
            pend_q       <= 1'b0;
            sel_q        <= 2'b00;
            level_addr_q <= '0;
            count_q      <= '0;
            hit_ack_q    <= 2'b00;
            hit_brick_q  <= 2'b00;
        end else begin
            for (int r = 0; r < MAP_TILES; r++) begin
                map_q[r] <= map_d[r];
            end
            state_q      <= state_d;
            row_q        <= row_d;
            wr_row_q     <= wr_row_d;
            addr_act_q   <= addr_act_d;
            pend_q       <= pend_d;
            sel_q        <= sel_d;
            level_addr_q <= level_addr_d;
            count_q      <= count_d;
            hit_ack_q    <= hit_ack_d;
            hit_brick_q  <= hit_brick_d;
        end
    end

    assign level_addr  = level_addr_q;
    assign load_busy   = (state_q != ST_IDLE);
    assign load_done   = (state_q == ST_DONE);
    assign hit_ack     = hit_ack_q;
    assign hit_brick   = hit_brick_q;
    assign brick_count = count_q;

    // Offset bits below tile resolution and above the field, plus the
    // pointer observation port, have no consumer here
    logic w_unused;
    assign w_unused = ^{w_dx[10:9], w_dx[3:0], w_dy[10:9], w_dy[3:0], w_arb_ptr};

endmodule
`default_nettype wire

// File: doc/brick_map_ctrl.md
BRICK_MAP_CTRL -- requirements
Module: brick_map_ctrl

Interface
REQ-001 SHALL have parameter ORIGIN_X, default 32, meaning playfield left edge in pixels.
REQ-002 SHALL have parameter ORIGIN_Y, default 32, meaning playfield top edge in pixels.
REQ-003 SHALL have parameter MAP_TILES, default 26, meaning playfield width and height in 16x16 tiles.
REQ-004 SHALL have port vga_clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports DrawX, DrawY  in  10 each  current pixel coordinate.
REQ-007 SHALL have port show_brick  out  1  current pixel lies on a present brick tile.
REQ-008 SHALL have port load_start  in  1  one-cycle pulse that starts a level load.
REQ-009 SHALL have port level_sel  in  2  level index, sampled on load_start.
REQ-010 SHALL have port level_addr  out  7  level ROM address {level_sel, row[4:0]}.
REQ-011 SHALL have port level_data  in  26  level ROM row; bit c is tile column c; valid 1 cycle after level_addr.
REQ-012 SHALL have ports load_busy  out  1, load_done  out  1 (one-cycle pulse).
REQ-013 SHALL have port hit_req  in  2  per-requester hit request, held until acked.
REQ-014 SHALL have ports hit_col0, hit_row0, hit_col1, hit_row1  in  5 each  target tile per requester, stable while requesting.
REQ-015 SHALL have ports hit_ack  out  2 (one-cycle pulse per requester) and hit_brick  out  2 (valid with hit_ack; 1 = a brick was destroyed).
REQ-016 SHALL have port brick_count  out  10  number of bricks currently present, 0..676.

Function
REQ-017 SHALL store the map as MAP_TILES rows of MAP_TILES bits.
REQ-018 SHALL compute show_brick combinationally, with zero-cycle latency: 1 iff DrawX-ORIGIN_X and DrawY-ORIGIN_Y both lie in [0, 16*MAP_TILES) and map[(DrawY-ORIGIN_Y)>>4][(DrawX-ORIGIN_X)>>4] is 1; the subtraction SHALL use 11-bit signed width so pixels left of or above the origin give 0.
REQ-019 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-020 IDLE->LOAD on load_start: SHALL latch level_sel, set row counter to 0, and clear brick_count.
REQ-021 In LOAD SHALL drive level_addr with row r in the cycle after r-1, and write level_data into map row r-1 one cycle later (pipelined); the load SHALL take 26 address cycles plus 1 drain cycle.
REQ-022 During LOAD SHALL add popcount(level_data) to brick_count on each row write.
REQ-023 After the last row write, the FSM SHALL enter DONE for one cycle, assert load_done, then return to IDLE; load_busy SHALL be 1 exactly in LOAD and DONE.
REQ-024 SHALL ignore load_start while load_busy is 1.
REQ-025 SHALL grant hit requests only in IDLE, at most one per cycle, using a round-robin arbiter between 2 requesters.
REQ-026 After a grant, the priority pointer SHALL move to the other requester; the pointer resets to requester 0.
REQ-027 For a request granted in cycle k, SHALL assert hit_ack[i] in cycle k+1 together with hit_brick[i] = the prior map bit, and SHALL clear that bit and decrement brick_count at the same edge if it was set.
REQ-028 SHALL NOT grant requester i in the cycle hit_ack[i] is high, so each held request produces exactly one ack.
REQ-029 Out-of-range coordinates (col or row >= MAP_TILES) SHALL be acked with hit_brick=0 and leave map and count unchanged.
REQ-030 Two requests to the same tile SHALL be served in arbitration order; the second SHALL receive hit_brick=0.
REQ-031 A request arriving during LOAD SHALL be held and served after the FSM returns to IDLE.

Reset
REQ-032 reset_n low SHALL asynchronously set: map all 0, FSM IDLE, row counter 0, brick_count 0, pointer 0, hit_ack 0, hit_brick 0, load_done 0, level_addr 0; show_brick then evaluates to 0.
REQ-033 Reset during LOAD SHALL abort the load with no load_done pulse.

Structure
REQ-034 SHALL place TILE_PX=16, MAP_TILES_DEFAULT=26, and the FSM state enum in shared package tank_pkg.
REQ-035 SHALL implement the round-robin grant logic as sub-module brick_hit_arbiter (inputs: req[1:0], enable; outputs: grant[1:0], registered pointer).

Verification
REQ-036 Load a ROM where all rows are 26'h3FFFFFF -> load_done in cycle 28 after load_start, brick_count=676, show_brick=1 at (32,32) and at (447,447), 0 at (448,447) and at (31,40).
REQ-037 Load a checkerboard, then sweep a full frame -> show_brick matches the golden model at every pixel.
REQ-038 Both requesters hit tile (3,5), which holds a brick -> requester 0 gets ack with hit_brick=1, requester 1 gets ack one cycle later with hit_brick=0; brick_count decrements by exactly 1.
REQ-039 Requester 1 asserts hit_req at col 26 -> ack with hit_brick=0; map and brick_count unchanged.
REQ-040 Raise hit_req[0] during LOAD -> no ack until after load_done, then exactly one ack.
REQ-041 Drive reset_n low at LOAD row 10 -> all outputs 0 immediately; no load_done; a subsequent load completes normally.
